// File: rtl/console_tx_pkg.sv
// Shared types for the console transmit arbiter: serializer state, port id and
// the baud divisor helper.
package console_tx_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  typedef logic port_id_t;

  function automatic int calc_divisor(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART serializer: IDLE/START/DATA/STOP state machine with a wrapping baud
// counter. A byte is taken on load while in IDLE; busy is high for the whole frame.
module uart_tx_serializer
  import console_tx_pkg::*;
#(
  parameter int DIVISOR = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output tx_state_t  state
);

  localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIVISOR - 1);

  tx_state_t     state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          baud_tick;

  assign baud_tick = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Baud counter restarts at every frame so each bit lasts exactly DIVISOR cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (state == ST_IDLE) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      if (load) shreg <= data;
    end else begin
      baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
      if (state == ST_DATA && baud_tick) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (load) state_nxt = ST_START;
      end
      ST_START: begin
        tx = 1'b0;
        if (baud_tick) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx = shreg[0];
        if (baud_tick && bit_cnt == 3'd7) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (baud_tick) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/console_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 transmit line between the CPU console (port 0)
// and the debug monitor (port 1). Define CONSOLE_TX_ARB_LOCK_EN to hold the grant per message.
module console_tx_arbiter
  import console_tx_pkg::*;
#(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic        tx,
  output logic        busy,
  output logic        active_port
);

  localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD);

  // Handshake: a byte moves when req_valid[p] & req_ready[p] on a rising edge.
  // req_ready is a one-cycle strobe, raised only in IDLE for the granted port and
  // derived combinationally from req_valid; a source may drop valid at any time.

  port_id_t                 last_grant;
  port_id_t                 grant;
  logic [NUM_PORTS-1:0]     eligible;
  logic                     accept;
  logic [7:0]               load_data;
  tx_state_t                ser_state;

`ifdef CONSOLE_TX_ARB_LOCK_EN
  logic     lock_active;
  port_id_t lock_port;

  // A byte without last opens (or continues) a lock on its port; last releases it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_port   <= 1'b0;
    end else if (accept) begin
      lock_active <= ~req_last[grant];
      lock_port   <= grant;
    end
  end

  assign eligible = lock_active ? (req_valid & (2'b01 << lock_port)) : req_valid;
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  always_comb begin
    grant = 1'b0;
    if (&eligible)       grant = ~last_grant;
    else if (eligible[1]) grant = 1'b1;
  end

  assign accept    = (ser_state == ST_IDLE) && !reset && (|eligible);
  assign load_data = grant ? req_data[15:8] : req_data[7:0];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant  <= 1'b1;
      active_port <= 1'b0;
    end else if (accept) begin
      last_grant  <= grant;
      active_port <= grant;
    end
  end

  uart_tx_serializer #(
    .DIVISOR (DIVISOR)
  ) u_ser (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .data  (load_data),
    .tx    (tx),
    .busy  (busy),
    .state (ser_state)
  );

endmodule

// File: tb/tb_console_tx_arbiter.sv
// Bench for console_tx_arbiter at DIVISOR=4: per-cycle reference model of grants and
// line waveform, plus a line decoder checked against an expected-byte queue.
module tb_console_tx_arbiter;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 250;
  localparam int DIV    = 4;
  localparam int FRAME  = 10 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx;
  logic        busy;
  logic        active_port;

  always #5 clk = ~clk;

  console_tx_arbiter #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx          (tx),
    .busy        (busy),
    .active_port (active_port)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Source queues: {last, byte}; valid is queue non-empty gated by a random enable.
  logic [8:0] src_q0[$];
  logic [8:0] src_q1[$];
  logic [1:0] gate = 2'b11;
  bit         rand_mode = 1'b0;

  logic [7:0] exp_q[$];

  // Reference model state
  int         m_cycle = 0;
  int         m_free = 0;
  bit         m_last = 1'b1;
  bit         m_locked = 1'b0;
  bit         m_lock_port = 1'b0;
  bit         m_fvalid = 1'b0;
  int         m_fstart = 0;
  logic [7:0] m_fbyte = 8'h00;
  bit         m_port = 1'b0;

  bit         mon_active = 1'b0;
  int         mon_t = 0;
  logic [7:0] mon_byte = 8'h00;

  task automatic push(input int p, input logic [7:0] b, input logic last);
    if (p == 0) src_q0.push_back({last, b});
    else        src_q1.push_back({last, b});
  endtask

  task automatic drive_inputs();
    if (rand_mode) gate = 2'($urandom_range(0, 3));
    else           gate = 2'b11;
    req_valid[0]  = (src_q0.size() != 0) && gate[0];
    req_data[7:0] = (src_q0.size() != 0) ? src_q0[0][7:0] : 8'($urandom);
    req_last[0]   = (src_q0.size() != 0) ? src_q0[0][8] : 1'($urandom);
    req_valid[1]  = (src_q1.size() != 0) && gate[1];
    req_data[15:8] = (src_q1.size() != 0) ? src_q1[0][7:0] : 8'($urandom);
    req_last[1]   = (src_q1.size() != 0) ? src_q1[0][8] : 1'($urandom);
  endtask

  task automatic model_reset();
    m_free   = m_cycle + 1;
    m_last   = 1'b1;
    m_locked = 1'b0;
    m_fvalid = 1'b0;
    m_port   = 1'b0;
    mon_active = 1'b0;
    exp_q.delete();
  endtask

  task automatic monitor();
    if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active = 1'b1;
        mon_t      = 0;
        mon_byte   = 8'h00;
      end
    end else begin
      mon_t++;
    end
    if (mon_active) begin
      if (mon_t >= 6 && mon_t <= 34 && ((mon_t - 6) % DIV) == 0)
        mon_byte[(mon_t - 6) / DIV] = tx;
      if (mon_t == 38) begin
        check("stop_bit", tx, 1);
        check("line_frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("line_byte", mon_byte, exp_q.pop_front());
      end
      if (mon_t == 39) mon_active = 1'b0;
    end
  endtask

  task automatic model_step();
    int         k;
    int         g;
    logic [1:0] elig;
    logic [1:0] exp_ready;
    logic       exp_tx;
    logic       exp_busy;
    logic [7:0] b;
    if (reset) begin
      check("rst_ready", req_ready, 0);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_active", active_port, 0);
      model_reset();
      m_cycle++;
      return;
    end
    exp_tx   = 1'b1;
    exp_busy = 1'b0;
    if (m_fvalid && m_cycle >= m_fstart && m_cycle < m_fstart + FRAME) begin
      k = (m_cycle - m_fstart) / DIV;
      exp_busy = 1'b1;
      if (k == 0)      exp_tx = 1'b0;
      else if (k <= 8) exp_tx = m_fbyte[k-1];
    end
    exp_ready = 2'b00;
    g = 0;
    if (m_cycle >= m_free) begin
      elig = req_valid;
`ifdef CONSOLE_TX_ARB_LOCK_EN
      if (m_locked) elig = req_valid & (m_lock_port ? 2'b10 : 2'b01);
`endif
      if (elig == 2'b11)      g = m_last ? 0 : 1;
      else if (elig == 2'b10) g = 1;
      else                    g = 0;
      if (elig != 2'b00) exp_ready = (g == 1) ? 2'b10 : 2'b01;
    end
    check("req_ready", req_ready, exp_ready);
    check("tx", tx, exp_tx);
    check("busy", busy, exp_busy);
    check("active_port", active_port, m_port);
    if (exp_ready != 2'b00) begin
      b = (g == 1) ? req_data[15:8] : req_data[7:0];
      exp_q.push_back(b);
`ifdef CONSOLE_TX_ARB_LOCK_EN
      m_locked    = !((g == 1) ? req_last[1] : req_last[0]);
      m_lock_port = (g == 1);
`endif
      if (g == 1) void'(src_q1.pop_front());
      else        void'(src_q0.pop_front());
      m_fvalid = 1'b1;
      m_fstart = m_cycle + 1;
      m_fbyte  = b;
      m_free   = m_cycle + 1 + FRAME;
      m_last   = (g == 1);
      m_port   = (g == 1);
    end
    monitor();
    m_cycle++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_inputs();
    @(negedge clk);
    model_step();
  endtask

  task automatic run_until_drained(input int budget);
    int n;
    n = 0;
    while ((src_q0.size() != 0 || src_q1.size() != 0 || m_cycle < m_free || mon_active) && n < budget) begin
      step();
      n++;
    end
    check("drained_in_budget", n < budget, 1);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b00;
    req_data  = 16'h0000;
    req_last  = 2'b00;
    repeat (3) step();
    reset = 1'b0;

    // Single byte from the CPU port
    push(0, 8'hA5, 1'b1);
    run_until_drained(200);

    // Contention: both sources, alternation expected
    push(0, 8'h11, 1'b1); push(1, 8'h22, 1'b1);
    push(0, 8'h33, 1'b1); push(1, 8'h44, 1'b1);
    run_until_drained(400);

    // Streaming from a single requester
    push(1, 8'h81, 1'b1); push(1, 8'h7E, 1'b1); push(1, 8'h00, 1'b1);
    run_until_drained(400);

    // Reset in the middle of a frame
    push(0, 8'hF0, 1'b1);
    repeat (2) step();
    while (m_fvalid && m_cycle < m_fstart + 14) step();
    @(posedge clk);
    #1;
    reset = 1'b1;
    src_q0.delete();
    src_q1.delete();
    drive_inputs();
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", req_ready, 0);
    @(negedge clk);
    model_step();
    repeat (2) step();
    reset = 1'b0;
    push(0, 8'h3C, 1'b1);
    run_until_drained(200);

    // Message lock: port 1 wins after port 0 took the last grant
    push(0, 8'h01, 1'b1);
    run_until_drained(200);
    push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b1);
    push(0, 8'h55, 1'b1); push(0, 8'h66, 1'b1);
    run_until_drained(400);

    // Valid dropped mid-frame
    push(0, 8'hC3, 1'b1); push(0, 8'h5A, 1'b1);
    repeat (20) step();
    src_q0.delete();
    repeat (70) step();

    // Randomized messages with random valid hold-off
    rand_mode = 1'b1;
    for (int r = 0; r < 14; r++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 3) != 0) begin
          int len;
          len = $urandom_range(1, 3);
          for (int i = 0; i < len; i++) push(p, 8'($urandom), (i == len - 1));
        end
      end
      run_until_drained(1200);
    end
    rand_mode = 1'b0;
    repeat (3) step();
    check("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
